// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_draw_arbiter                                             |
// | Description : Round-robin arbiter that hands the single frame-buffer       |
// |               write port to one sprite draw client at a time and registers |
// |               the owner's pixel onto the VGA adapter port.                 |
// | Ports       : clk, resetn        - clock, synchronous active-low reset     |
// |               req/done/we_in     - per-client request, last-pixel, write   |
// |               x_in/y_in/color_in - packed per-client pixel fields          |
// |               grant              - registered one-hot owner (0 = none)     |
// |               busy               - req & ~grant, tells waiters to hold     |
// |               vga_x/y/colour/plot- registered adapter outputs              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_draw_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 7
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  input  logic [8*N-1:0] x_in,
  input  logic [7*N-1:0] y_in,
  input  logic [3*N-1:0] color_in,
  input  logic [N-1:0]   we_in,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   busy,
  output logic [7:0]     vga_x,
  output logic [6:0]     vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);

  localparam int           IDX_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] GRANT_LSB = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]        vga_x_q, vga_x_d;
  logic [6:0]        vga_y_q, vga_y_d;
  logic [2:0]        vga_colour_q, vga_colour_d;
  logic              vga_plot_q, vga_plot_d;

  // Cyclic search for the first requester starting at rr_ptr. The candidate
  // index is one bit wider so the wrap is an explicit subtract, which keeps
  // non-power-of-two N correct.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!pick_found && req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Owner's slice of the client buses; everything from non-owners is ignored.
  logic [7:0] own_x;
  logic [6:0] own_y;
  logic [2:0] own_colour;
  logic       own_we;
  logic       own_done;
  logic       own_req;
  logic       own_release;

  assign own_x       = x_in[8*owner_q +: 8];
  assign own_y       = y_in[7*owner_q +: 7];
  assign own_colour  = color_in[3*owner_q +: 3];
  assign own_we      = we_in[owner_q];
  assign own_done    = done[owner_q];
  assign own_req     = req[owner_q];
  assign own_release = own_done | ~own_req | (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    hold_cnt_d   = hold_cnt_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d    = GRANT_LSB << pick_idx;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
          state_d    = S_OWN;
        end
      end
      S_OWN: begin
        vga_x_d      = own_x;
        vga_y_d      = own_y;
        vga_colour_d = own_colour;
        // A done pixel is plotted even if req falls with it; a bare req drop
        // abandons the pixel presented that cycle.
        vga_plot_d   = own_we & (own_req | own_done);
        hold_cnt_d   = hold_cnt_q + HOLD_W'(1);
        if (own_release) begin
          grant_d  = '0;
          rr_ptr_d = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        // Dead cycle so waiting clients see busy before the next owner plots.
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = req & ~grant_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule
`default_nettype wire

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Sits directly downstream of the sprite draw FSM/datapath pairs (player, bullet, enemies). Each pair produces one pixel per cycle as x, y, colour and a write enable.
- Grants the single frame-buffer write port to one client at a time using round-robin order. Registers the winner's pixel onto the adapter port.
- Drives a per-client busy signal, so a client that is not granted holds in its wait state and does not start an erase/draw sequence.

Parameters:
- N, 4, number of draw clients (2..8).
- MAX_HOLD, 64, maximum cycles one client may own the port before it is forcibly released.
- HOLD_W, 7, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req  in  N  client i requests the port; held high for the whole erase+draw sequence
- done  in  N  client i is driving its final pixel this cycle
- x_in  in  8*N  packed x coordinates; client i occupies bits [8i+7:8i]
- y_in  in  7*N  packed y coordinates; client i occupies bits [7i+6:7i]
- color_in  in  3*N  packed colours; client i occupies bits [3i+2:3i]
- we_in  in  N  per-client write enable
- grant  out  N  one-hot owner, or zero when no client owns the port
- busy  out  N  busy[i] = req[i] & ~grant[i]; combinational from req and the registered grant
- vga_x  out  8  registered pixel x
- vga_y  out  7  registered pixel y
- vga_colour  out  3  registered pixel colour
- vga_plot  out  1  registered plot strobe

Behaviour:
- Reset (resetn low at a clk edge): state S_IDLE, grant=0, rr_ptr=0, hold_cnt=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0. A reset taken mid-ownership drops the grant immediately and produces no further plot.
- S_IDLE:
  - If req is zero, remain in S_IDLE.
  - Otherwise select the first set req bit, searching cyclically from index rr_ptr upward.
  - Set grant to that client's one-hot value, clear hold_cnt, go to S_OWN.
- S_OWN (owner k):
  - Each cycle, vga_x/vga_y/vga_colour take client k's slice, and vga_plot takes we_in[k]. Latency is exactly 1 cycle from client inputs to adapter outputs.
  - hold_cnt increments every cycle.
  - Release when done[k]=1, or req[k]=0, or hold_cnt==MAX_HOLD-1.
  - On a done-triggered release, the pixel presented in that cycle is still plotted.
  - On a req-drop release, the pixel presented in that cycle is not plotted (vga_plot=0).
  - On release: grant goes to 0, rr_ptr becomes (k+1) mod N, go to S_GAP.
- S_GAP:
  - One dead cycle: vga_plot=0, grant=0. Then go to S_IDLE.
  - Guarantees at least one non-plot cycle between owners, so a client sees busy before the next owner's pixels appear.
- In all states other than S_OWN, vga_plot registers 0. vga_x, vga_y and vga_colour hold their last values.
- Non-owner we_in, done and coordinates are ignored entirely.
- done[k] and req[k] falling in the same cycle is treated as a done release, so the pixel is plotted.
- Requests that arrive during S_OWN or S_GAP wait. Arbitration happens only in S_IDLE.
- Any req[j] held continuously is granted within N ownerships (no starvation).
- Minimum turnaround: owner k releases at cycle t; grant is 0 at t+1 and t+2; the next grant is visible at t+3.
- Index arithmetic is mod N. For N not a power of two, rr_ptr wraps from N-1 to 0 explicitly.
- Outputs never glitch within a cycle; all outputs except busy are registered.

Test Plan:
- Reset then req=4'b0001, client 0 drives x=10, y=20, colour=3'b111, we=1 for 12 cycles with done on the 12th -> grant=0001 one cycle after req; vga_plot high for 12 consecutive cycles with vga_x=10 one cycle after each input; grant returns to 0.
- req=4'b1111 held permanently, each client asserts done on its 4th owned cycle -> grant order 0001, 0010, 0100, 1000, 0001; exactly 2 zero-grant cycles between owners; busy is never high for the current owner.
- Client 2 owns the port and never asserts done, MAX_HOLD=64 -> release after 64 owned cycles; rr_ptr=3; client 3 is granted next if requesting.
- Client 1 drops req mid-draw with we=1 in that cycle -> that pixel is not plotted; vga_plot=0 next cycle; grant=0 for 2 cycles.
- resetn pulled low during client 0's 5th owned cycle -> next cycle grant=0, vga_plot=0, vga_x=0; after reset with req=4'b0110, client 1 is granted first.
- Non-owner client 3 toggles we_in and done while client 0 owns -> no effect on vga outputs or on the grant sequence.
